// File: rtl/id_ex_stage.sv
// ID/EX pipeline register.
// Detects load-use hazards against the instruction currently in EX, inserts a
// single bubble for them, squashes the ID instruction on a taken branch/jump,
// freezes on a downstream stall and bypasses the WB write into the ID operands
// so a same-cycle register-file write is never missed.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,

  // ID-stage instruction
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [3:0]       id_alu_ctrl,
  input  logic             id_ALUSrc,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_MemtoReg,

  // WB-stage write port, used for the ID operand bypass
  input  logic [4:0]       wb_rd,
  input  logic             wb_RegWrite,
  input  logic [XLEN-1:0]  wb_data,

  // Pipeline control
  input  logic             flush_ex,
  input  logic             ext_stall,

  // EX-stage view
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_alu_ctrl,
  output logic             ex_ALUSrc,
  output logic             ex_RegWrite,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             ex_MemtoReg,

  output logic             stall,
  output logic [CNT_W-1:0] lu_stall_cnt
);

  // One record for everything that crosses the ID/EX boundary. An all-zero
  // record is exactly a bubble: invalid, x0 indices, no write enables.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alu_ctrl;
    logic            alu_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
  } ex_reg_t;

  localparam ex_reg_t BUBBLE = '0;

  ex_reg_t         ex_q;
  ex_reg_t         id_entry;
  logic            rs1_dep;
  logic            rs2_dep;
  logic            load_use;
  logic            byp_rs1;
  logic            byp_rs2;
  logic            count_lu;
  logic [CNT_W-1:0] cnt_q;

  // Hazard detection: a load in EX whose destination a real ID instruction reads.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    rs1_dep  = 1'b0;
    rs2_dep  = 1'b0;
    load_use = 1'b0;
    if (ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && id_valid) begin
      rs1_dep  = id_uses_rs1 && (id_rs1 == ex_q.rd);
      rs2_dep  = id_uses_rs2 && (id_rs2 == ex_q.rd);
      load_use = rs1_dep || rs2_dep;
    end
  end

  // A taken branch kills the ID instruction, so it never has to wait.
  assign stall = ~flush_ex & (ext_stall | load_use);

  // A load-use bubble is only counted on the edge that actually inserts it.
  assign count_lu = load_use & ~flush_ex & ~ext_stall;

  // WB bypass: the register file is read before the WB write lands, so take
  // the WB result directly when it targets a source register (never x0).
  always_comb begin
    byp_rs1 = wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == id_rs1);
    byp_rs2 = wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == id_rs2);
  end

  // Assemble the record an instruction in ID would occupy in EX.
  always_comb begin
    id_entry            = BUBBLE;
    id_entry.valid      = 1'b1;
    id_entry.pc         = id_pc;
    id_entry.rs1_data   = byp_rs1 ? wb_data : id_rs1_data;
    id_entry.rs2_data   = byp_rs2 ? wb_data : id_rs2_data;
    id_entry.imm        = id_imm;
    id_entry.rs1        = id_rs1;
    id_entry.rs2        = id_rs2;
    id_entry.rd         = id_rd;
    id_entry.alu_ctrl   = id_alu_ctrl;
    id_entry.alu_src    = id_ALUSrc;
    id_entry.reg_write  = id_RegWrite;
    id_entry.mem_read   = id_MemRead;
    id_entry.mem_write  = id_MemWrite;
    id_entry.mem_to_reg = id_MemtoReg;
  end

  // Pipeline register update in priority order: reset, flush, hold, bubble, load.
  // NOTE: the whole record is reset, data included, because every field is a
  // visible output and must read as a clean bubble straight out of reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= BUBBLE;
    end else if (flush_ex) begin
      ex_q <= BUBBLE;
    end else if (ext_stall) begin
      ex_q <= ex_q;
    end else if (load_use || !id_valid) begin
      ex_q <= BUBBLE;
    end else begin
      ex_q <= id_entry;
    end
  end

  // Saturating count of load-use bubble cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (count_lu && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_data  = ex_q.rs1_data;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_alu_ctrl  = ex_q.alu_ctrl;
  assign ex_ALUSrc    = ex_q.alu_src;
  assign ex_RegWrite  = ex_q.reg_write;
  assign ex_MemRead   = ex_q.mem_read;
  assign ex_MemWrite  = ex_q.mem_write;
  assign ex_MemtoReg  = ex_q.mem_to_reg;
  assign lu_stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized
// run, all compared against a behavioural model of the EX-stage contents.
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_uses_rs1, id_uses_rs2;
  logic [XLEN-1:0]  id_rs1_data, id_rs2_data, id_imm;
  logic [3:0]       id_alu_ctrl;
  logic             id_ALUSrc, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg;
  logic [4:0]       wb_rd;
  logic             wb_RegWrite;
  logic [XLEN-1:0]  wb_data;
  logic             flush_ex, ext_stall;

  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [3:0]       ex_alu_ctrl;
  logic             ex_ALUSrc, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg;
  logic             stall;
  logic [CNT_W-1:0] lu_stall_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_ctrl(id_alu_ctrl), .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_MemtoReg(id_MemtoReg),
    .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite), .wb_data(wb_data),
    .flush_ex(flush_ex), .ext_stall(ext_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg),
    .stall(stall), .lu_stall_cnt(lu_stall_cnt)
  );

  always #5 clk = ~clk;

  // Expected EX-stage contents
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc, d1, d2, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [3:0]      alu;
    logic            alusrc, rw, mr, mw, m2r;
  } ex_t;

  ex_t         m_ex;
  int unsigned m_cnt;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic ex_t obs();
    ex_t o;
    o.valid = ex_valid;    o.pc  = ex_pc;      o.d1     = ex_rs1_data; o.d2 = ex_rs2_data;
    o.imm   = ex_imm;      o.rs1 = ex_rs1;     o.rs2    = ex_rs2;      o.rd = ex_rd;
    o.alu   = ex_alu_ctrl; o.alusrc = ex_ALUSrc; o.rw   = ex_RegWrite;
    o.mr    = ex_MemRead;  o.mw  = ex_MemWrite; o.m2r   = ex_MemtoReg;
    return o;
  endfunction

  // Reference rules
  function automatic logic model_load_use();
    if (!(m_ex.valid && m_ex.mr && m_ex.rd != 0 && id_valid)) return 1'b0;
    return (id_uses_rs1 && id_rs1 == m_ex.rd) || (id_uses_rs2 && id_rs2 == m_ex.rd);
  endfunction

  function automatic logic model_stall();
    return !flush_ex && (ext_stall || model_load_use());
  endfunction

  function automatic logic [XLEN-1:0] reg_read(input logic [4:0] r, input logic [XLEN-1:0] d);
    return (wb_RegWrite && wb_rd != 0 && wb_rd == r) ? wb_data : d;
  endfunction

  // Advance model and clock by one edge, sampling 1 ns after the edge.
  task automatic tick();
    ex_t         nx;
    int unsigned nc;
    logic        lu;
    nx = m_ex;
    nc = m_cnt;
    lu = model_load_use();
    if (rst) begin
      nx = '0; nc = 0;
    end else if (flush_ex) begin
      nx = '0;
    end else if (ext_stall) begin
      nx = m_ex;
    end else if (lu) begin
      nx = '0;
      if (nc < CNT_MAX) nc = nc + 1;
    end else if (!id_valid) begin
      nx = '0;
    end else begin
      nx.valid = 1'b1;      nx.pc  = id_pc;
      nx.d1 = reg_read(id_rs1, id_rs1_data);
      nx.d2 = reg_read(id_rs2, id_rs2_data);
      nx.imm = id_imm;      nx.rs1 = id_rs1;    nx.rs2 = id_rs2;    nx.rd = id_rd;
      nx.alu = id_alu_ctrl; nx.alusrc = id_ALUSrc; nx.rw = id_RegWrite;
      nx.mr = id_MemRead;   nx.mw = id_MemWrite; nx.m2r = id_MemtoReg;
    end
    @(posedge clk);
    #1;
    m_ex  = nx;
    m_cnt = nc;
  endtask

  task automatic idle();
    id_valid = 0; id_pc = '0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_alu_ctrl = 0; id_ALUSrc = 0; id_RegWrite = 0; id_MemRead = 0; id_MemWrite = 0;
    id_MemtoReg = 0; wb_rd = 0; wb_RegWrite = 0; wb_data = '0; flush_ex = 0; ext_stall = 0;
  endtask

  // Present one instruction in ID; pc/imm/alu fields are randomized.
  task automatic drive_id(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic load,
                          input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2);
    id_valid = 1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_rs1_data = d1; id_rs2_data = d2;
    id_pc = $urandom(); id_imm = $urandom(); id_alu_ctrl = 4'($urandom_range(0, 15));
    id_ALUSrc = load; id_RegWrite = 1; id_MemRead = load; id_MemWrite = 0; id_MemtoReg = load;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick();
    tick();
    n_checks++;
    if (obs() !== ex_t'('0)) begin
      n_errors++; $display("FAIL reset_ex_regs: got %h, want 0", obs());
    end
    n_checks++;
    if (stall !== 1'b0) begin
      n_errors++; $display("FAIL reset_stall: got %b, want 0", stall);
    end
    n_checks++;
    if (lu_stall_cnt !== '0) begin
      n_errors++; $display("FAIL reset_cnt: got %0d, want 0", lu_stall_cnt);
    end
    rst = 0;
  endtask

  task automatic test_basic();
    idle();
    drive_id(5'd5, 5'd1, 5'd2, 1, 1, 0, 32'h11, 32'h22);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_errors++; $display("FAIL basic_stall: got %b, want 0", stall);
    end
    tick();
    n_checks++;
    if (ex_rd !== 5'd5 || ex_RegWrite !== 1'b1 || ex_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_ctrl: rd=%0d rw=%b v=%b, want rd=5 rw=1 v=1", ex_rd, ex_RegWrite, ex_valid);
    end
    n_checks++;
    if (ex_rs1_data !== 32'h11 || ex_rs2_data !== 32'h22) begin
      n_errors++;
      $display("FAIL basic_operands: got %h/%h, want 11/22", ex_rs1_data, ex_rs2_data);
    end
    n_checks++;
    if (obs() !== m_ex) begin
      n_errors++; $display("FAIL basic_regs: got %h, want %h", obs(), m_ex);
    end
  endtask

  task automatic test_load_use();
    int unsigned c0;
    idle();
    drive_id(5'd7, 5'd2, 5'd0, 1, 0, 1, 32'h100, 32'h0);   // LW x7
    tick();
    c0 = m_cnt;
    drive_id(5'd8, 5'd1, 5'd7, 1, 1, 0, 32'h3, 32'h4);     // ADD x8, x1, x7
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_errors++; $display("FAIL lu_stall: got %b, want 1", stall);
    end
    tick();
    n_checks++;
    if (ex_rd !== 5'd0 || ex_valid !== 1'b0 || ex_MemRead !== 1'b0) begin
      n_errors++; $display("FAIL lu_bubble: rd=%0d v=%b mr=%b, want 0/0/0", ex_rd, ex_valid, ex_MemRead);
    end
    n_checks++;
    if (lu_stall_cnt !== CNT_W'(c0 + 1)) begin
      n_errors++; $display("FAIL lu_cnt: got %0d, want %0d", lu_stall_cnt, c0 + 1);
    end
    n_checks++;
    if (stall !== 1'b0) begin
      n_errors++; $display("FAIL lu_release: stall got %b, want 0", stall);
    end
    tick();
    n_checks++;
    if (ex_rd !== 5'd8 || ex_valid !== 1'b1 || ex_rs2 !== 5'd7) begin
      n_errors++; $display("FAIL lu_advance: rd=%0d v=%b rs2=%0d, want 8/1/7", ex_rd, ex_valid, ex_rs2);
    end
  endtask

  task automatic test_x0();
    int unsigned c0;
    idle();
    c0 = m_cnt;
    drive_id(5'd0, 5'd2, 5'd0, 1, 0, 1, 32'h0, 32'h0);     // LW x0
    tick();
    drive_id(5'd9, 5'd0, 5'd0, 1, 1, 0, 32'h0, 32'h0);     // reads x0
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_errors++; $display("FAIL x0_stall: got %b, want 0", stall);
    end
    tick();
    n_checks++;
    if (ex_rd !== 5'd9 || ex_valid !== 1'b1) begin
      n_errors++; $display("FAIL x0_advance: rd=%0d v=%b, want 9/1", ex_rd, ex_valid);
    end
    drive_id(5'd7, 5'd2, 5'd0, 1, 0, 1, 32'h0, 32'h0);     // LW x7
    tick();
    drive_id(5'd10, 5'd1, 5'd7, 1, 0, 0, 32'h5, 32'h6);    // rs2=7 but unused
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_errors++; $display("FAIL unused_rs2_stall: got %b, want 0", stall);
    end
    tick();
    n_checks++;
    if (ex_rd !== 5'd10 || lu_stall_cnt !== CNT_W'(c0)) begin
      n_errors++; $display("FAIL unused_rs2_advance: rd=%0d cnt=%0d, want 10/%0d", ex_rd, lu_stall_cnt, c0);
    end
  endtask

  task automatic test_flush_and_hold();
    int unsigned c0;
    ex_t         snap;
    idle();
    drive_id(5'd7, 5'd2, 5'd0, 1, 0, 1, 32'h0, 32'h0);     // LW x7
    tick();
    c0 = m_cnt;
    drive_id(5'd8, 5'd7, 5'd1, 1, 1, 0, 32'h1, 32'h2);     // dependent
    flush_ex = 1;
    ext_stall = 1;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_errors++; $display("FAIL flush_stall: got %b, want 0", stall);
    end
    tick();
    n_checks++;
    if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || lu_stall_cnt !== CNT_W'(c0)) begin
      n_errors++; $display("FAIL flush_bubble: v=%b rd=%0d cnt=%0d, want 0/0/%0d", ex_valid, ex_rd, lu_stall_cnt, c0);
    end
    // Load in flight frozen by a 3-cycle downstream stall, dependent waiting in ID
    flush_ex = 0;
    ext_stall = 0;
    drive_id(5'd7, 5'd2, 5'd0, 1, 0, 1, 32'h0, 32'h0);
    tick();
    snap = m_ex;
    drive_id(5'd8, 5'd7, 5'd1, 1, 1, 0, 32'h1, 32'h2);
    ext_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (stall !== 1'b1) begin
        n_errors++; $display("FAIL hold_stall[%0d]: got %b, want 1", i, stall);
      end
      tick();
      n_checks++;
      if (obs() !== snap || ex_rd !== 5'd7 || lu_stall_cnt !== CNT_W'(c0)) begin
        n_errors++; $display("FAIL hold_frozen[%0d]: got %h cnt=%0d, want %h cnt=%0d", i, obs(), lu_stall_cnt, snap, c0);
      end
    end
    ext_stall = 0;
    tick();
    n_checks++;
    if (ex_valid !== 1'b0 || lu_stall_cnt !== CNT_W'(c0 + 1)) begin
      n_errors++; $display("FAIL hold_then_bubble: v=%b cnt=%0d, want 0/%0d", ex_valid, lu_stall_cnt, c0 + 1);
    end
    tick();
    n_checks++;
    if (ex_rd !== 5'd8 || ex_valid !== 1'b1) begin
      n_errors++; $display("FAIL hold_then_advance: rd=%0d v=%b, want 8/1", ex_rd, ex_valid);
    end
  endtask

  task automatic test_bypass();
    idle();
    drive_id(5'd6, 5'd3, 5'd4, 1, 1, 0, 32'h1, 32'h2);
    wb_RegWrite = 1; wb_rd = 5'd3; wb_data = 32'hDEAD;
    tick();
    n_checks++;
    if (ex_rs1_data !== 32'hDEAD || ex_rs2_data !== 32'h2) begin
      n_errors++; $display("FAIL bypass_rs1: got %h/%h, want dead/2", ex_rs1_data, ex_rs2_data);
    end
    wb_rd = 5'd0;
    tick();
    n_checks++;
    if (ex_rs1_data !== 32'h1) begin
      n_errors++; $display("FAIL bypass_x0: got %h, want 1", ex_rs1_data);
    end
    wb_rd = 5'd4; wb_data = 32'hBEEF;
    tick();
    n_checks++;
    if (ex_rs1_data !== 32'h1 || ex_rs2_data !== 32'hBEEF) begin
      n_errors++; $display("FAIL bypass_rs2: got %h/%h, want 1/beef", ex_rs1_data, ex_rs2_data);
    end
    wb_RegWrite = 0;
    tick();
    n_checks++;
    if (ex_rs2_data !== 32'h2) begin
      n_errors++; $display("FAIL bypass_no_we: got %h, want 2", ex_rs2_data);
    end
  endtask

  task automatic test_saturation();
    int unsigned want;
    idle();
    want = m_cnt;
    for (int k = 0; k < int'(CNT_MAX) + 4; k++) begin
      drive_id(5'd7, 5'd2, 5'd0, 1, 0, 1, 32'h0, 32'h0);   // LW x7
      tick();
      drive_id(5'd8, 5'd7, 5'd7, 1, 1, 0, 32'h0, 32'h0);   // dependent -> bubble
      tick();
      if (want < CNT_MAX) want = want + 1;
      n_checks++;
      if (lu_stall_cnt !== CNT_W'(want)) begin
        n_errors++; $display("FAIL sat_cnt[%0d]: got %0d, want %0d", k, lu_stall_cnt, want);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_valid    = ($urandom_range(0, 7) != 0);
      id_pc       = $urandom();
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_rd       = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      id_rs1_data = $urandom();
      id_rs2_data = $urandom();
      id_imm      = $urandom();
      id_alu_ctrl = 4'($urandom_range(0, 15));
      id_ALUSrc   = 1'($urandom_range(0, 1));
      id_RegWrite = 1'($urandom_range(0, 1));
      id_MemRead  = 1'($urandom_range(0, 1));
      id_MemWrite = 1'($urandom_range(0, 1));
      id_MemtoReg = 1'($urandom_range(0, 1));
      wb_rd       = 5'($urandom_range(0, 3));
      wb_RegWrite = 1'($urandom_range(0, 1));
      wb_data     = $urandom();
      flush_ex    = ($urandom_range(0, 7) == 0);
      ext_stall   = ($urandom_range(0, 5) == 0);
      rst         = ($urandom_range(0, 63) == 0);
      #1;
      n_checks++;
      if (stall !== model_stall()) begin
        n_errors++; $display("FAIL rand_stall[%0d]: got %b, want %b", i, stall, model_stall());
      end
      tick();
      n_checks++;
      if (obs() !== m_ex) begin
        n_errors++; $display("FAIL rand_regs[%0d]: got %h, want %h", i, obs(), m_ex);
      end
      n_checks++;
      if (lu_stall_cnt !== CNT_W'(m_cnt)) begin
        n_errors++; $display("FAIL rand_cnt[%0d]: got %0d, want %0d", i, lu_stall_cnt, m_cnt);
      end
    end
    rst = 0;
  endtask

  initial begin
    m_ex  = '0;
    m_cnt = 0;
    rst   = 1;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_load_use();
    test_x0();
    test_flush_and_hold();
    test_bypass();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
